// File: rtl/prio_encoder_hs.sv
// Sticky request collector: serves the highest pending request index over a valid/ready handshake.
// Requests latch until served; a request into an already-pending bit raises the overrun flag.
module prio_encoder_hs #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req_in,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         ovf,
  input  logic         ovf_clr
);

  logic [N-1:0] pending_reg;
  logic [N-1:0] pending_next;
  logic         out_valid_reg;
  logic [W-1:0] out_idx_reg;
  logic         ovf_reg;
  logic         ovf_next;

  logic         accept;
  logic         load;
  logic [W-1:0] sel;
  logic [N-1:0] clr_mask;
  logic [N-1:0] lost;

  assign accept = out_valid_reg & out_ready;
  assign load   = en & (~out_valid_reg | out_ready) & (|pending_reg);

  // Ascending scan so the last hit, the highest set bit, wins.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (pending_reg[i]) sel = W'(i);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign clr_mask[gi] = load & (sel == W'(gi));
      assign lost[gi]     = req_in[gi] & pending_reg[gi] & ~clr_mask[gi];
    end
  endgenerate

  // Set wins over clear, both for pending bits and for the overrun flag.
  assign pending_next = (pending_reg & ~clr_mask) | req_in;
  assign ovf_next     = (|lost) | (ovf_reg & ~ovf_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_idx_reg   <= '0;
      ovf_reg       <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      ovf_reg     <= ovf_next;
      if (load) begin
        out_valid_reg <= 1'b1;
        out_idx_reg   <= sel;
      end else if (accept) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_idx   = out_idx_reg;
  assign pending   = pending_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_prio_encoder_hs.sv
// Directed bench for prio_encoder_hs: hand-computed expectations checked with immediate assertions.
module tb_prio_encoder_hs;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] req_in;
  logic       out_ready;
  logic       out_valid;
  logic [1:0] out_idx;
  logic [3:0] pending;
  logic       ovf;
  logic       ovf_clr;

  int checks   = 0;
  int failures = 0;

  prio_encoder_hs #(.N(4), .W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_in    (req_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .pending   (pending),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [1:0] idx,
                           input logic [3:0] p, input logic o);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    if (v) check({tag, ".idx"}, 32'(out_idx), 32'(idx));
    check({tag, ".pending"}, 32'(pending), 32'(p));
    check({tag, ".ovf"}, 32'(ovf), 32'(o));
    $display("step %-10s valid=%0b idx=%0d pending=%b ovf=%0b", tag, out_valid, out_idx, pending, ovf);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; req_in = 4'b0000; out_ready = 1'b1; ovf_clr = 1'b0;
    step();
    check_all("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
    check("reset.idx", 32'(out_idx), 32'd0);
    rst_n = 1'b1;

    // single request
    req_in = 4'b0100; step(); check_all("single0", 1'b0, 2'd0, 4'b0100, 1'b0);
    req_in = 4'b0000; step(); check_all("single1", 1'b1, 2'd2, 4'b0000, 1'b0);
    step(); check_all("single2", 1'b0, 2'd0, 4'b0000, 1'b0);
    check("single2.idx_hold", 32'(out_idx), 32'd2);

    // priority order 3,1,0
    req_in = 4'b1011; step(); check_all("prio0", 1'b0, 2'd0, 4'b1011, 1'b0);
    req_in = 4'b0000; step(); check_all("prio1", 1'b1, 2'd3, 4'b0011, 1'b0);
    step(); check_all("prio2", 1'b1, 2'd1, 4'b0001, 1'b0);
    step(); check_all("prio3", 1'b1, 2'd0, 4'b0000, 1'b0);
    step(); check_all("prio4", 1'b0, 2'd0, 4'b0000, 1'b0);

    // backpressure
    out_ready = 1'b0;
    req_in = 4'b0011; step(); check_all("bp0", 1'b0, 2'd0, 4'b0011, 1'b0);
    req_in = 4'b0000; step(); check_all("bp1", 1'b1, 2'd1, 4'b0001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(); check_all("bp_hold", 1'b1, 2'd1, 4'b0001, 1'b0);
    end
    out_ready = 1'b1; step(); check_all("bp_rel", 1'b1, 2'd0, 4'b0000, 1'b0);
    step(); check_all("bp_end", 1'b0, 2'd0, 4'b0000, 1'b0);

    // set wins, then overrun, then clear
    req_in = 4'b1000; step(); check_all("sw0", 1'b0, 2'd0, 4'b1000, 1'b0);
    req_in = 4'b1000; step(); check_all("sw1", 1'b1, 2'd3, 4'b1000, 1'b0);
    out_ready = 1'b0;
    req_in = 4'b1000; step(); check_all("ovf_set", 1'b1, 2'd3, 4'b1000, 1'b1);
    req_in = 4'b1000; ovf_clr = 1'b1; step(); check_all("ovf_race", 1'b1, 2'd3, 4'b1000, 1'b1);
    req_in = 4'b0000; step(); check_all("ovf_clr", 1'b1, 2'd3, 4'b1000, 1'b0);
    ovf_clr = 1'b0; out_ready = 1'b1;
    step(); check_all("sw2", 1'b1, 2'd3, 4'b0000, 1'b0);
    step(); check_all("sw3", 1'b0, 2'd0, 4'b0000, 1'b0);

    // en gating
    en = 1'b0;
    req_in = 4'b1111; step(); check_all("en0", 1'b0, 2'd0, 4'b1111, 1'b0);
    req_in = 4'b0000; step(); check_all("en1", 1'b0, 2'd0, 4'b1111, 1'b0);
    en = 1'b1;
    step(); check_all("en_i3", 1'b1, 2'd3, 4'b0111, 1'b0);
    step(); check_all("en_i2", 1'b1, 2'd2, 4'b0011, 1'b0);
    step(); check_all("en_i1", 1'b1, 2'd1, 4'b0001, 1'b0);
    step(); check_all("en_i0", 1'b1, 2'd0, 4'b0000, 1'b0);
    step(); check_all("en_end", 1'b0, 2'd0, 4'b0000, 1'b0);

    // async reset mid-operation
    req_in = 4'b0100; step(); check_all("ar0", 1'b0, 2'd0, 4'b0100, 1'b0);
    req_in = 4'b0110; step(); check_all("ar1", 1'b1, 2'd2, 4'b0110, 1'b0);
    req_in = 4'b0000; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_all("ar_rst", 1'b0, 2'd0, 4'b0000, 1'b0);
    check("ar_rst.idx", 32'(out_idx), 32'd0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check_all("ar_idle", 1'b0, 2'd0, 4'b0000, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
